// File: rtl/inst_mem_writer.sv
// Streams 32-bit instruction words into a byte-wide, big-endian instruction memory.
// Ports: clk/rst, start/base_addr/word_count load request, in_valid/in_word/in_ready
//   word stream, mem_we/mem_addr/mem_wdata byte write port, busy/done/error status.
module inst_mem_writer #(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              in_valid,
   input  logic [31:0]       in_word,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int EW = ADDR_W + CNT_W + 2;
   // One past the last legal byte address; a load may end exactly here.
   localparam logic [EW-1:0] LIMIT = EW'(1) << ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_WORD,
      WRITE,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              error_q, error_d;

   logic [EW-1:0]     end_addr;
   logic              misaligned;
   logic              overflow;
   logic              start_bad;

   // Address bits above the memory depth are don't-care.
   logic unused_hi;
   if (ADDR_W < 32) begin : g_hi
      assign unused_hi = ^base_addr[31:ADDR_W];
   end else begin : g_nohi
      assign unused_hi = 1'b0;
   end

   function automatic logic [7:0] byte_of(
      input logic [31:0] w,
      input logic [1:0]  i
   );
      logic [7:0] b;
      case (i)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   // Bounds check is done wide so a large count cannot wrap past the top.
   always_comb begin
      end_addr   = EW'(base_addr[ADDR_W-1:0])
                 + EW'({word_count, 2'b00});
      misaligned = (base_addr[1:0] != 2'b00);
      overflow   = (end_addr > LIMIT);
      start_bad  = misaligned || overflow;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      idx_d   = idx_q;
      word_d  = word_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      error_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (start_bad) begin
                  error_d = 1'b1;
               end else if (word_count == '0) begin
                  state_d = DONE;
               end else begin
                  ptr_d   = base_addr[ADDR_W-1:0];
                  rem_d   = word_count;
                  state_d = WAIT_WORD;
               end
            end
         end

         WAIT_WORD: begin
            if (in_valid) begin
               // Present the first byte on the edge of acceptance.
               word_d  = in_word;
               idx_d   = 2'd0;
               addr_d  = ptr_q;
               wdata_d = in_word[31:24];
               state_d = WRITE;
            end
         end

         WRITE: begin
            if (idx_q == 2'd3) begin
               ptr_d   = ptr_q + ADDR_W'(4);
               rem_d   = rem_q - CNT_W'(1);
               state_d = (rem_q == CNT_W'(1)) ? DONE : WAIT_WORD;
            end else begin
               idx_d   = idx_q + 2'd1;
               addr_d  = addr_q + ADDR_W'(1);
               wdata_d = byte_of(word_q, idx_q + 2'd1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         error_q <= error_d;
      end
   end

   // addr/wdata only move when a new byte is launched, so they
   // hold their last values while mem_we is low.
   assign in_ready  = (state_q == WAIT_WORD);
   assign mem_we    = (state_q == WRITE);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign error     = error_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_inst_mem_writer.sv
// Directed bench for inst_mem_writer with a byte-write scoreboard.
// Ports: drives all DUT inputs, monitors the byte port and status outputs.
module tb_inst_mem_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] word_count;
   logic        in_valid;
   logic [31:0] in_word;
   logic        in_ready;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        busy;
   logic        done;
   logic        error;

   always #5 clk = ~clk;

   inst_mem_writer #(.ADDR_W(16), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .in_valid   (in_valid),
      .in_word    (in_word),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] mem [0:65535];
   int vectors     = 0;
   int miscompares = 0;
   int we_count    = 0;
   int done_count  = 0;
   int err_count   = 0;
   int rdy_count   = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Byte-port monitor: every write must match the next scoreboard entry.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         we_count++;
         mem[mem_addr] = mem_wdata;
         check("wr_expected", 64'(exp_q.size() > 0), 64'(1));
         if (exp_q.size() > 0) begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(e.a));
            check("wr_data", 64'(mem_wdata), 64'(e.d));
         end
      end
      if (in_ready === 1'b1 && mem_we === 1'b1)
         check("rdy_we_excl", 64'(in_ready & mem_we), 64'(0));
      if (done === 1'b1) done_count++;
      if (error === 1'b1) err_count++;
      if (in_ready === 1'b1) rdy_count++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] a, input logic [31:0] w);
      exp_q.push_back('{a: a,         d: w[31:24]});
      exp_q.push_back('{a: a + 16'd1, d: w[23:16]});
      exp_q.push_back('{a: a + 16'd2, d: w[15:8]});
      exp_q.push_back('{a: a + 16'd3, d: w[7:0]});
   endtask

   task automatic do_start(input logic [31:0] b, input logic [15:0] c);
      start      = 1'b1;
      base_addr  = b;
      word_count = c;
      tick();
      start      = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_word  = w;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            tick();
            in_valid = 1'b0;
            return;
         end
         tick();
      end
      in_valid = 1'b0;
      check("send_timeout", 64'(in_ready), 64'(1));
   endtask

   task automatic wait_done(input int max);
      for (int i = 0; i < max; i++) begin
         if (done) return;
         tick();
      end
      check("done_timeout", 64'(done), 64'(1));
   endtask

   function automatic logic [31:0] rd32(input logic [15:0] a);
      return {mem[a], mem[a + 16'd1], mem[a + 16'd2], mem[a + 16'd3]};
   endfunction

   int w0, d0, r0, e0;

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      in_valid   = 1'b0;
      in_word    = '0;
      tick();
      tick();
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_mem_we", 64'(mem_we), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_error", 64'(error), 64'(0));
      check("rst_addr", 64'(mem_addr), 64'(0));
      check("rst_wdata", 64'(mem_wdata), 64'(0));
      rst = 1'b0;
      tick();

      // Single word at 0, with cycle-exact latency.
      push_word(16'h0000, 32'h12345678);
      do_start(32'h0, 16'd1);
      check("t1_ready", 64'(in_ready), 64'(1));
      check("t1_busy", 64'(busy), 64'(1));
      send_word(32'h12345678, 0);
      check("t1_we0", 64'(mem_we), 64'(1));
      check("t1_a0", 64'(mem_addr), 64'(16'h0000));
      check("t1_d0", 64'(mem_wdata), 64'(8'h12));
      check("t1_rdy_w", 64'(in_ready), 64'(0));
      tick();
      tick();
      tick();
      check("t1_a3", 64'(mem_addr), 64'(16'h0003));
      check("t1_d3", 64'(mem_wdata), 64'(8'h78));
      tick();
      check("t1_done", 64'(done), 64'(1));
      check("t1_we_off", 64'(mem_we), 64'(0));
      tick();
      check("t1_done_off", 64'(done), 64'(0));
      check("t1_idle", 64'(busy), 64'(0));
      check("t1_read", 64'(rd32(16'h0000)), 64'(32'h12345678));

      // Three words at 0x100 with gaps on in_valid.
      push_word(16'h0100, 32'hDEADBEEF);
      push_word(16'h0104, 32'h0A0B0C0D);
      push_word(16'h0108, 32'hF00DCAFE);
      d0 = done_count;
      do_start(32'h100, 16'd3);
      send_word(32'hDEADBEEF, 2);
      send_word(32'h0A0B0C0D, 2);
      send_word(32'hF00DCAFE, 2);
      wait_done(20);
      check("t2_hold_a", 64'(mem_addr), 64'(16'h010B));
      check("t2_hold_d", 64'(mem_wdata), 64'(8'hFE));
      tick();
      tick();
      check("t2_one_done", 64'(done_count - d0), 64'(1));
      check("t2_idle_a", 64'(mem_addr), 64'(16'h010B));
      check("t2_rd0", 64'(rd32(16'h0100)), 64'(32'hDEADBEEF));
      check("t2_rd1", 64'(rd32(16'h0104)), 64'(32'h0A0B0C0D));
      check("t2_rd2", 64'(rd32(16'h0108)), 64'(32'hF00DCAFE));

      // Load ending exactly at the top of memory.
      push_word(16'hFFFC, 32'hCAFEBABE);
      do_start(32'hFFFC, 16'd1);
      send_word(32'hCAFEBABE, 0);
      wait_done(20);
      tick();
      check("t3_top", 64'(mem[16'hFFFF]), 64'(8'hBE));
      check("t3_rd", 64'(rd32(16'hFFFC)), 64'(32'hCAFEBABE));

      // Overrun and misaligned starts are rejected.
      w0 = we_count;
      e0 = err_count;
      do_start(32'hFFFC, 16'd2);
      check("t3_err_ovf", 64'(error), 64'(1));
      check("t3_ovf_busy", 64'(busy), 64'(0));
      tick();
      check("t3_err_off", 64'(error), 64'(0));
      do_start(32'h0002, 16'd1);
      check("t3_err_mis", 64'(error), 64'(1));
      check("t3_mis_rdy", 64'(in_ready), 64'(0));
      tick();
      tick();
      check("t3_no_we", 64'(we_count - w0), 64'(0));
      check("t3_err_cnt", 64'(err_count - e0), 64'(2));

      // Zero-length load goes straight to DONE.
      w0 = we_count;
      r0 = rdy_count;
      do_start(32'h40, 16'd0);
      check("t4_done", 64'(done), 64'(1));
      check("t4_rdy", 64'(in_ready), 64'(0));
      tick();
      check("t4_done_off", 64'(done), 64'(0));
      tick();
      check("t4_no_we", 64'(we_count - w0), 64'(0));
      check("t4_no_rdy", 64'(rdy_count - r0), 64'(0));

      // start during the second word's writes is ignored.
      push_word(16'h0200, 32'h11223344);
      push_word(16'h0204, 32'h55667788);
      w0 = we_count;
      d0 = done_count;
      do_start(32'h200, 16'd2);
      send_word(32'h11223344, 0);
      send_word(32'h55667788, 0);
      start      = 1'b1;
      base_addr  = 32'h0;
      word_count = 16'd5;
      tick();
      start      = 1'b0;
      wait_done(20);
      tick();
      tick();
      tick();
      check("t5_we_cnt", 64'(we_count - w0), 64'(8));
      check("t5_one_done", 64'(done_count - d0), 64'(1));
      check("t5_idle", 64'(busy), 64'(0));
      check("t5_rd", 64'(rd32(16'h0204)), 64'(32'h55667788));

      // Reset in the second write cycle aborts silently.
      exp_q.push_back('{a: 16'h0300, d: 8'hAA});
      exp_q.push_back('{a: 16'h0301, d: 8'hBB});
      d0 = done_count;
      do_start(32'h300, 16'd1);
      send_word(32'hAABBCCDD, 0);
      tick();
      check("t6_we_pre", 64'(mem_we), 64'(1));
      rst = 1'b1;
      tick();
      check("t6_we", 64'(mem_we), 64'(0));
      check("t6_busy", 64'(busy), 64'(0));
      check("t6_addr", 64'(mem_addr), 64'(0));
      rst = 1'b0;
      tick();
      tick();
      tick();
      check("t6_no_done", 64'(done_count - d0), 64'(0));
      check("t6_q_empty", 64'(exp_q.size()), 64'(0));
      push_word(16'h0300, 32'h0BADF00D);
      do_start(32'h300, 16'd1);
      send_word(32'h0BADF00D, 1);
      wait_done(20);
      tick();
      check("t6_reload", 64'(rd32(16'h0300)), 64'(32'h0BADF00D));

      check("end_q_empty", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1);
   end

endmodule
